// File: rtl/div_const_pkg.sv
// Shared types and constants for the div_const sequential divider.
// Selector decode maps x to a 3-bit divisor; zero marks an invalid selector.
package div_const_pkg;

  localparam int DW = 8;
  localparam int RW = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] SEL_DIV1 = 3'b001;
  localparam logic [2:0] SEL_DIV2 = 3'b010;
  localparam logic [2:0] SEL_DIV3 = 3'b011;
  localparam logic [2:0] SEL_DIV4 = 3'b100;

  function automatic logic [2:0] sel_to_div(input logic [2:0] sel);
    case (sel)
      SEL_DIV1: sel_to_div = 3'd1;
      SEL_DIV2: sel_to_div = 3'd2;
      SEL_DIV3: sel_to_div = 3'd3;
      SEL_DIV4: sel_to_div = 3'd4;
      default:  sel_to_div = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/div_const_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step (
  input  logic [2:0] p,
  input  logic       bit_in,
  input  logic [2:0] div,
  output logic [2:0] p_next,
  output logic       q_bit
);

  logic [2:0] shifted;

  always_comb begin
    shifted = {p[1:0], bit_in};
    q_bit   = (shifted >= div);
    p_next  = q_bit ? (shifted - div) : shifted;
  end

endmodule

// File: rtl/div_const.sv
// Sequential 8-bit divider by a constant 1..4 with valid/ready handshakes.
// Optional macro DIV_CONST_ERR_EN drives err high for an invalid selector.
module div_const
  import div_const_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] i,
  input  logic [2:0]    x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [RW-1:0] r,
  output logic          err
);

  state_t        state;
  state_t        state_next;
  logic [2:0]    cnt;
  logic [DW-1:0] dvd;
  logic [DW-2:0] qw;
  logic [2:0]    div_r;
  logic [2:0]    p;
  logic [2:0]    p_next;
  logic [2:0]    div_in;
  logic          q_bit;
  logic          sel_ok;
  logic          accept;
  logic          last;

  assign div_in = sel_to_div(x);
  assign sel_ok = (div_in != 3'd0);
  assign accept = in_valid && (state == IDLE);
  assign last   = (state == RUN) && (cnt == 3'd0);

  div_step u_step (
    .p      (p),
    .bit_in (dvd[DW-1]),
    .div    (div_r),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = sel_ok ? RUN : DONE;
      end
      RUN: begin
        if (cnt == 3'd0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working quotient keeps only the low 7 bits; the 8th arrives with the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      dvd   <= '0;
      qw    <= '0;
      div_r <= '0;
      p     <= '0;
      q     <= '0;
      r     <= '0;
    end else if (accept) begin
      dvd   <= i;
      div_r <= div_in;
      p     <= '0;
      qw    <= '0;
      cnt   <= sel_ok ? 3'd7 : 3'd0;
      if (!sel_ok) begin
        q <= '0;
        r <= '0;
      end
    end else if (state == RUN) begin
      dvd <= {dvd[DW-2:0], 1'b0};
      p   <= p_next;
      qw  <= {qw[DW-3:0], q_bit};
      if (!last) cnt <= cnt - 3'd1;
      if (last) begin
        q <= {qw, q_bit};
        r <= p_next[RW-1:0];
      end
    end
  end

`ifdef DIV_CONST_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err <= 1'b0;
    else if (accept) err <= !sel_ok;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div_const.sv
// Self-checking bench for div_const: directed scenarios plus random operands
// compared against plain integer division.
module tb_div_const;

`ifdef DIV_CONST_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] i;
  logic [2:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [1:0] r;
  logic       err;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  div_const dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .err       (err)
  );

  // Drives one operation through both handshakes; returns latency and results.
  task automatic run_op(input logic [7:0] di, input logic [2:0] dx, input int stall,
                        output int lat, output logic [7:0] oq, output logic [1:0] orr,
                        output logic oe);
    int w;
    @(negedge clk);
    in_valid = 1'b1; i = di; x = dx;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    oq = q; orr = r; oe = err;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    tot_cnt++; if (q !== 8'd0) $display("FAIL rst_q: got %0d expected 0", q); else pass_cnt++;
    tot_cnt++; if (r !== 2'd0) $display("FAIL rst_r: got %0d expected 0", r); else pass_cnt++;
    tot_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_directed;
    int lat; logic [7:0] oq; logic [1:0] orr; logic oe;
    run_op(8'd200, 3'b011, 0, lat, oq, orr, oe);
    tot_cnt++; if (oq !== 8'd66) $display("FAIL d200_3_q: got %0d expected 66", oq); else pass_cnt++;
    tot_cnt++; if (orr !== 2'd2) $display("FAIL d200_3_r: got %0d expected 2", orr); else pass_cnt++;
    tot_cnt++; if (oe !== 1'b0) $display("FAIL d200_3_err: got %b expected 0", oe); else pass_cnt++;
    tot_cnt++; if (lat != 8) $display("FAIL d200_3_latency: got %0d expected 8", lat); else pass_cnt++;
    run_op(8'd255, 3'b100, 0, lat, oq, orr, oe);
    tot_cnt++; if (oq !== 8'd63) $display("FAIL d255_4_q: got %0d expected 63", oq); else pass_cnt++;
    tot_cnt++; if (orr !== 2'd3) $display("FAIL d255_4_r: got %0d expected 3", orr); else pass_cnt++;
    run_op(8'd7, 3'b001, 0, lat, oq, orr, oe);
    tot_cnt++; if (oq !== 8'd7) $display("FAIL d7_1_q: got %0d expected 7", oq); else pass_cnt++;
    tot_cnt++; if (orr !== 2'd0) $display("FAIL d7_1_r: got %0d expected 0", orr); else pass_cnt++;
    tot_cnt++; if (lat != 8) $display("FAIL d7_1_latency: got %0d expected 8", lat); else pass_cnt++;
  endtask

  task automatic test_invalid_sel;
    int lat; logic [7:0] oq; logic [1:0] orr; logic oe;
    run_op(8'h55, 3'b000, 0, lat, oq, orr, oe);
    tot_cnt++; if (lat != 0) $display("FAIL inv_latency: got %0d expected 0 edges past acceptance", lat); else pass_cnt++;
    tot_cnt++; if (oq !== 8'd0) $display("FAIL inv_q: got %0d expected 0", oq); else pass_cnt++;
    tot_cnt++; if (orr !== 2'd0) $display("FAIL inv_r: got %0d expected 0", orr); else pass_cnt++;
    tot_cnt++; if (oe !== ERR_EXP) $display("FAIL inv_err: got %b expected %b", oe, ERR_EXP); else pass_cnt++;
    run_op(8'd13, 3'b010, 0, lat, oq, orr, oe);
    tot_cnt++; if (oe !== 1'b0) $display("FAIL err_clears: got %b expected 0", oe); else pass_cnt++;
    tot_cnt++; if (oq !== 8'd6 || orr !== 2'd1) $display("FAIL after_inv: got %0d r%0d expected 6 r1", oq, orr); else pass_cnt++;
  endtask

  task automatic test_stall;
    int n;
    @(negedge clk);
    in_valid = 1'b1; i = 8'd9; x = 3'b010;
    @(posedge clk); #1;
    i = 8'd0; x = 3'b001;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    tot_cnt++; if (n != 8) $display("FAIL stall_latency: got %0d expected 8", n); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tot_cnt++;
      if (out_valid !== 1'b1 || q !== 8'd4 || r !== 2'd1 || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d: got ov=%b q=%0d r=%0d ir=%b expected ov=1 q=4 r=1 ir=0",
                 k, out_valid, q, r, in_ready);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tot_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready); else pass_cnt++;
    tot_cnt++; if (q !== 8'd4) $display("FAIL stall_q_kept: got %0d expected 4", q); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] oq; logic [1:0] orr; logic oe; logic seen;
    @(negedge clk);
    in_valid = 1'b1; i = 8'd100; x = 3'b011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tot_cnt++; if (out_valid !== 1'b0 || q !== 8'd0 || in_ready !== 1'b1) $display("FAIL mid_rst: got ov=%b q=%0d ir=%b expected ov=0 q=0 ir=1", out_valid, q, in_ready); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    tot_cnt++; if (seen !== 1'b0) $display("FAIL mid_rst_no_result: got out_valid=1 expected 0"); else pass_cnt++;
    run_op(8'd100, 3'b011, 0, lat, oq, orr, oe);
    tot_cnt++; if (oq !== 8'd33 || orr !== 2'd1) $display("FAIL after_rst_op: got %0d r%0d expected 33 r1", oq, orr); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; i = 8'd10; x = 3'b010;
    @(posedge clk); #1;
    i = 8'd11; x = 3'b011;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    tot_cnt++; if (n != 8) $display("FAIL b2b_lat1: got %0d expected 8", n); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (q !== 8'd5 || r !== 2'd0) $display("FAIL b2b_res1: got %0d r%0d expected 5 r0", q, r); else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_handshake: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid); else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_accept2: got ir=%b expected 0", in_ready); else pass_cnt++;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    tot_cnt++; if (n != 8) $display("FAIL b2b_lat2: got %0d expected 8", n); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (q !== 8'd3 || r !== 2'd2) $display("FAIL b2b_res2: got %0d r%0d expected 3 r2", q, r); else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    int lat; logic [7:0] oq; logic [1:0] orr; logic oe;
    logic [7:0] di; logic [2:0] dx; int d;
    int exp_q, exp_r, exp_lat; logic exp_e;
    for (int n = 0; n < 24; n++) begin
      di = 8'($urandom_range(0, 255));
      dx = 3'($urandom_range(0, 7));
      d  = (dx >= 3'd1 && dx <= 3'd4) ? int'(dx) : 0;
      if (d == 0) begin exp_q = 0; exp_r = 0; exp_e = ERR_EXP; exp_lat = 0; end
      else begin exp_q = int'(di) / d; exp_r = int'(di) % d; exp_e = 1'b0; exp_lat = 8; end
      run_op(di, dx, int'($urandom_range(0, 3)), lat, oq, orr, oe);
      tot_cnt++;
      if (int'(oq) != exp_q || int'(orr) != exp_r || oe !== exp_e || lat != exp_lat)
        $display("FAIL rand%0d i=%0d x=%0d: got q=%0d r=%0d err=%b lat=%0d expected q=%0d r=%0d err=%b lat=%0d",
                 n, di, dx, oq, orr, oe, lat, exp_q, exp_r, exp_e, exp_lat);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; i = '0; x = '0;
    test_reset;
    test_directed;
    test_invalid_sel;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
